muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the mini-processor execute stage. It takes the same two 32-bit operands presented to the ALU and produces the HI/LO register pair that the ALU's `hi`/`low` outputs only stub out. It runs one multiply or divide at a time over multiple cycles, holds the result in architectural HI/LO registers, and accepts direct HI/LO writes for move-to-HI/LO instructions.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `CNT_W`, 6, iteration counter width; must hold `WIDTH`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- `input1`  in  WIDTH  multiplicand or dividend.
- `input2`  in  WIDTH  multiplier or divisor.
- `flush`  in  1  abort any in-flight operation.
- `hi_we`, `lo_we`  in  1  direct write enables for HI and LO.
- `wdata`  in  WIDTH  data for direct writes.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse; new `hi`/`low` are valid in the same cycle.
- `div_by_zero`  out  1  set at done of a divide with `input2 == 0`; cleared on the next accepted start.
- `hi`, `low`  out  WIDTH  architectural HI/LO registers.

## Operation
- States:
  - IDLE: on `start`, latch `op`, `input1`, `input2`, then go to PREP.
  - PREP: 1 cycle. Record the operand signs for signed ops and convert operands to magnitudes. Clear the 2×WIDTH accumulator and the counter.
  - RUN: exactly WIDTH cycles, counter 0..WIDTH-1.
    - Multiply: shift-add on the magnitudes.
    - Divide: restoring shift-subtract.
  - FIX: 1 cycle. Apply sign correction, write `hi`/`low`, pulse `done`, then return to IDLE.
- Result mapping:
  - Multiply: `hi` = upper WIDTH bits, `low` = lower WIDTH bits of the full 2×WIDTH product. Signed product is two's complement.
  - Divide: `low` = quotient truncated toward zero, `hi` = remainder with the sign of the dividend.
- Boundary cases:
  - Divide by zero: `low` = all ones, `hi` = `input1` unchanged, `div_by_zero` = 1. The normal latency is still spent.
  - Signed overflow, DIV of 0x80000000 by 0xFFFFFFFF: `low` = 0x80000000, `hi` = 0, no flag.
  - `start` while busy: ignored, with no effect on the in-flight operation.
  - `hi_we`/`lo_we` in IDLE: register updated at the next edge. While busy they are ignored.
  - `start` and a write in the same IDLE cycle: the write lands, and the operation result overwrites it at done.
  - `flush` in any non-IDLE state: next state is IDLE, `hi`/`low` and `div_by_zero` unchanged, no `done`. In IDLE, `flush` has priority over `start`.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `low` = 0, counter and accumulator = 0.
- Latency: start accepted at edge E0; `busy` = 1 after E0; PREP runs between E0 and E1; RUN covers E1–E33; FIX ends at E34.
- At E34: `hi`/`low` are updated, `done` = 1 for one cycle, and `busy` = 0. This gives 34 cycles from start to done.
- A new `start` can be accepted in the `done` cycle, because the state is IDLE.
- Operands are latched at E0, so later changes on `input1`/`input2` have no effect.
- All outputs are registered; no combinational path from inputs to outputs.
- Asserting reset mid-operation returns every output to its reset value immediately.

## Structure
- `muldiv_pkg`: `op` encodings (`OP_MULU`, `OP_MUL`, `OP_DIVU`, `OP_DIV`), the state enum (IDLE/PREP/RUN/FIX), and the width constants.
- Sign conversion and sign correction are natural to split out as sub-module `muldiv_sign_fix`, a combinational negate-if-needed helper used in PREP and FIX. Control and datapath stay in `muldiv_unit`.

## Test plan
- Reset, then MULU 0xFFFFFFFF × 0xFFFFFFFF: `done` at 34 cycles with `hi` = 0xFFFFFFFE, `low` = 0x00000001, `busy` high for exactly 34 cycles.
- MUL −3 × 7: `hi` = 0xFFFFFFFF, `low` = 0xFFFFFFEB. DIV −7 / 2: `low` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- DIVU 100 / 0: `low` = 0xFFFFFFFF, `hi` = 100, `div_by_zero` = 1; the flag clears on the next start.
- DIV 0x80000000 / 0xFFFFFFFF: `low` = 0x80000000, `hi` = 0, `div_by_zero` = 0.
- `start` pulsed mid-RUN with different operands: the original result is returned at 34 cycles, and no second `done` follows.
- `flush` at cycle 10, then `hi_we` with `wdata` = 0x1234: no `done`; after the write `hi` = 0x1234 and `low` = the prior value. Asserting `rst_n` low mid-RUN drives all outputs to 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        RUN  = 2'b10,
        FIX  = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MUL) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Negate-if-needed helper: result = neg ? -val : val (two's complement).
// Latency: combinational.
// Backpressure: none.
// Ports: val (operand), neg (negate request), result (possibly negated value).
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit producing the architectural HI/LO pair.
// Latency: 34 cycles from accepted start to done (PREP + WIDTH RUN + FIX).
// Backpressure: one op at a time; start ignored while busy, flush aborts.
// Ports: clk/rst_n; start/op/input1/input2 launch an op; flush aborts;
//        hi_we/lo_we/wdata write HI/LO directly in IDLE;
//        busy/done/div_by_zero status; hi/low architectural registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] low
);

    state_e             state;
    state_e             state_nxt;
    op_e                op_r;
    logic [WIDTH-1:0]   a_r;        // multiplicand / dividend (magnitude after PREP)
    logic [WIDTH-1:0]   b_r;        // multiplier / divisor (magnitude after PREP)
    logic [2*WIDTH-1:0] acc;        // product, or {remainder, quotient}
    logic [CNT_W-1:0]   cnt;
    logic               sign_a;
    logic               sign_b;
    logic               accept;
    logic               finish;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                // flush outranks start while idle
                if (start && !flush) begin
                    state_nxt = PREP;
                    accept    = 1'b1;
                end
            end
            PREP: state_nxt = flush ? IDLE : RUN;
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
                finish    = !flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------- sign handling ----------------
    // The two WIDTH-wide helpers convert operands to magnitudes in PREP and
    // restore remainder/quotient signs in FIX; the wide one fixes the product.
    logic [WIDTH-1:0]   fx_a_in, fx_b_in, fx_a_out, fx_b_out;
    logic               fx_a_neg, fx_b_neg;
    logic [2*WIDTH-1:0] prod_out;

    always_comb begin
        fx_a_in  = a_r;
        fx_a_neg = op_is_signed(op_r) & a_r[WIDTH-1];
        fx_b_in  = b_r;
        fx_b_neg = op_is_signed(op_r) & b_r[WIDTH-1];
        if (state == FIX) begin
            fx_a_in  = acc[2*WIDTH-1:WIDTH];   // remainder takes dividend sign
            fx_a_neg = sign_a;
            fx_b_in  = acc[WIDTH-1:0];         // quotient negative if signs differ
            fx_b_neg = sign_a ^ sign_b;
        end
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
        .val    (fx_a_in),
        .neg    (fx_a_neg),
        .result (fx_a_out)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
        .val    (fx_b_in),
        .neg    (fx_b_neg),
        .result (fx_b_out)
    );

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val    (acc),
        .neg    (sign_a ^ sign_b),
        .result (prod_out)
    );

    // ---------------- iteration step ----------------
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    always_comb begin
        // shift-add: add multiplicand to the upper half when the multiplier LSB is set
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_r[0] ? {1'b0, a_r} : '0);
        // restoring divide: bring in next dividend bit, subtract if it fits
        div_shift = {acc[2*WIDTH-1:WIDTH], a_r[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_r};
        div_ge    = (div_shift >= {1'b0, b_r});
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= OP_MULU;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            cnt         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            low         <= '0;
        end else begin
            done <= finish;

            if (state == IDLE) begin
                if (hi_we) hi  <= wdata;
                if (lo_we) low <= wdata;
            end

            if (accept) begin
                op_r        <= op_e'(op);
                a_r         <= input1;
                b_r         <= input2;
                div_by_zero <= 1'b0;
            end

            case (state)
                PREP: begin
                    a_r    <= fx_a_out;
                    b_r    <= fx_b_out;
                    sign_a <= fx_a_neg;
                    sign_b <= fx_b_neg;
                    acc    <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_is_div(op_r)) begin
                        acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ge};
                        a_r <= a_r << 1;
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        b_r <= b_r >> 1;
                    end
                end
                FIX: begin
                    if (finish) begin
                        if (op_is_div(op_r)) begin
                            // a zero divisor leaves |dividend| as remainder, so hi
                            // comes back as the original dividend; only low needs forcing
                            hi          <= fx_a_out;
                            low         <= (b_r == '0) ? '1 : fx_b_out;
                            div_by_zero <= (b_r == '0);
                        end else begin
                            hi  <= prod_out[2*WIDTH-1:WIDTH];
                            low <= prod_out[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] input1 = '0;
    logic [W-1:0] input2 = '0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] low;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .input1      (input1),
        .input2      (input2),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .low         (low)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definitions.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
        logic [63:0] p;
        int          sa;
        int          sb;
        longint      sp;
        sa = a;
        sb = b;
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                sp = longint'(sa) * longint'(sb);
                p  = sp;
                eh = p[63:32];
                el = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    el = '1; eh = a; ez = 1'b1;
                end else begin
                    el = a / b; eh = a % b;
                end
            end
            default: begin
                if (b == 0) begin
                    el = '1; eh = a; ez = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = '0;
                end else begin
                    el = sa / sb; eh = sa % sb;
                end
            end
        endcase
    endtask

    // mode 0 plain, 1 stray start mid-RUN, 2 direct writes while busy,
    // 3 direct writes in the same cycle as start
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mode);
        logic [W-1:0] eh, el, wv;
        logic         ez;
        int           lat;
        int           busy_cnt;
        int           extra;
        model(o, a, b, eh, el, ez);
        wv = $urandom;
        @(negedge clk);
        start = 1'b1; op = o; input1 = a; input2 = b;
        if (mode == 3) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = wv;
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        input1 = $urandom; input2 = $urandom; op = 2'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("dbz_cleared_on_start", 32'(div_by_zero), 32'd0);
        if (mode == 3) begin
            check("write_with_start_hi", hi, wv);
            check("write_with_start_lo", low, wv);
        end
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            if (mode == 1) begin
                start = (lat == 10);
                if (lat == 10) begin
                    op = 2'($urandom); input1 = $urandom; input2 = $urandom;
                end
            end
            if (mode == 2) begin
                hi_we = (lat == 5); lo_we = (lat == 5); wdata = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("latency", 32'(lat), 32'd34);
        check("busy_cycles", 32'(busy_cnt), 32'd34);
        check("busy_at_done", 32'(busy), 32'd0);
        check("hi", hi, eh);
        check("low", low, el);
        check("div_by_zero", 32'(div_by_zero), 32'(ez));
        last_hi = eh;
        last_lo = el;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        if (mode == 1) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) extra++;
                @(negedge clk);
            end
            check("no_second_done", 32'(extra), 32'd0);
            check("hi_kept", hi, eh);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dcnt;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_hi", hi, '0);
        check("rst_low", low, '0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        // directed arithmetic cases
        run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(OP_MUL,  32'hFFFF_FFFD, 32'd7, 0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
        run_op(OP_DIVU, 32'd100, 32'd0, 0);
        run_op(OP_MULU, 32'd3, 32'd5, 0);          // dbz must clear at this start
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_DIV,  32'h8000_0000, 32'd0, 0);
        run_op(OP_MUL,  32'h8000_0000, 32'h8000_0000, 0);

        // protocol cases
        run_op(OP_MULU, 32'd1234, 32'd5678, 1);
        run_op(OP_DIVU, 32'hDEAD_BEEF, 32'd17, 2);
        run_op(OP_DIV,  32'hFFFF_FF00, 32'd9, 3);

        // randomized
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom), pick(), pick(), 0);
        end

        // flush mid-RUN, then direct writes
        @(negedge clk);
        start = 1'b1; op = OP_MULU; input1 = $urandom; input2 = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(dcnt), 32'd0);
        check("flush_hi_kept", hi, last_hi);
        check("flush_low_kept", low, last_lo);
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("hi_write", hi, 32'h0000_1234);
        check("hi_write_low_kept", low, last_lo);
        lo_we = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        lo_we = 1'b0;
        check("lo_write", low, 32'h0000_ABCD);
        check("lo_write_hi_kept", hi, 32'h0000_1234);

        // flush outranks start in IDLE
        start = 1'b1; flush = 1'b1; op = OP_MULU;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_over_start", 32'(busy), 32'd0);

        // asynchronous reset mid-RUN
        start = 1'b1; op = OP_DIVU; input1 = 32'd1000; input2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_hi", hi, '0);
        check("midrst_low", low, '0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
